// File: rtl/mem_resp_pkg.sv
// Shared types for the data-side response path: load-op bit indices, pending-entry record, extension helpers.
package mem_resp_pkg;

  typedef logic [31:0] uint32_t;

  localparam int LOAD_OP_W   = 7;
  localparam int LOAD_OP_LB  = 0;
  localparam int LOAD_OP_LBU = 1;
  localparam int LOAD_OP_LH  = 2;
  localparam int LOAD_OP_LHU = 3;
  localparam int LOAD_OP_LW  = 4;
  localparam int LOAD_OP_LWL = 5;
  localparam int LOAD_OP_LWR = 6;

  typedef struct packed {
    logic                 is_load;
    logic [LOAD_OP_W-1:0] load_op;
    logic [1:0]           addr_lo;
    uint32_t              rt_old;
    uint32_t              rdata;
    logic                 done;
    logic                 cancel;
  } mem_pend_t;

  function automatic uint32_t sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic uint32_t sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data extraction: picks byte/half/word from the aligned word and merges lwl/lwr with rt.
module mem_load_align
  import mem_resp_pkg::*;
(
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr_lo,
  input  uint32_t              rt_old,
  input  uint32_t              rdata,
  output uint32_t              load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lanes selected by the low address bits
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Final result per load op; lwl/lwr keep the rt bytes the unaligned access does not cover
  always_comb begin
    load_data = 32'h0000_0000;
    if (load_op[LOAD_OP_LB]) begin
      load_data = sext8(byte_s);
    end else if (load_op[LOAD_OP_LBU]) begin
      load_data = {24'h00_0000, byte_s};
    end else if (load_op[LOAD_OP_LH]) begin
      load_data = sext16(half_s);
    end else if (load_op[LOAD_OP_LHU]) begin
      load_data = {16'h0000, half_s};
    end else if (load_op[LOAD_OP_LW]) begin
      load_data = rdata;
    end else if (load_op[LOAD_OP_LWL]) begin
      case (addr_lo)
        2'd0:    load_data = {rdata[7:0],  rt_old[23:0]};
        2'd1:    load_data = {rdata[15:0], rt_old[15:0]};
        2'd2:    load_data = {rdata[23:0], rt_old[7:0]};
        2'd3:    load_data = rdata;
        default: load_data = 32'h0000_0000;
      endcase
    end else if (load_op[LOAD_OP_LWR]) begin
      case (addr_lo)
        2'd0:    load_data = rdata;
        2'd1:    load_data = {rt_old[31:24], rdata[31:8]};
        2'd2:    load_data = {rt_old[31:16], rdata[31:16]};
        2'd3:    load_data = {rt_old[31:8],  rdata[31:24]};
        default: load_data = 32'h0000_0000;
      endcase
    end else begin
      load_data = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/mem_resp.sv
// In-order response tracker for the data SRAM interface; drops responses of flushed requests.
// Define MEM_RESP_OUT_REG_EN to register the resp_* outputs (data_ok -> resp_valid latency 2).
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_fire,
  output logic                 req_ready,
  input  logic                 req_is_load,
  input  logic [LOAD_OP_W-1:0] req_load_op,
  input  logic [1:0]           req_addr_lo,
  input  logic [31:0]          req_rt_old,
  input  logic                 data_data_ok,
  input  logic [31:0]          data_rdata,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_is_load,
  output logic [31:0]          resp_data,
  output logic                 idle,
  output logic                 err_unexp
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one wrap bit so full/empty and filled/unfilled are unambiguous
  mem_pend_t        ent_r [DEPTH];
  logic [PTR_W-1:0] wr_r, fill_r, rd_r;
  logic             err_r;

  logic [PTR_W-1:0] count_s;
  logic             not_full_s, push_s, fill_s, head_busy_s;
  logic             head_valid_s, head_drop_s, pop_s, free_s;
  mem_pend_t        head_s;
  uint32_t          align_data_s, head_data_s;

  assign count_s      = wr_r - rd_r;
  assign not_full_s   = (count_s != PTR_W'(DEPTH));
  assign push_s       = req_fire & not_full_s;
  assign fill_s       = data_data_ok & (fill_r != wr_r);
  assign head_busy_s  = (count_s != PTR_W'(0));
  assign head_s       = ent_r[rd_r[IDX_W-1:0]];
  assign head_valid_s = head_busy_s & head_s.done & ~head_s.cancel & ~flush;
  assign head_drop_s  = head_busy_s & head_s.done & head_s.cancel;
  assign free_s       = head_drop_s | pop_s;
  assign head_data_s  = head_s.is_load ? align_data_s : 32'h0000_0000;

  assign req_ready = not_full_s;
  assign idle      = ~head_busy_s;
  assign err_unexp = err_r;

  mem_load_align u_align (
    .load_op   (head_s.load_op),
    .addr_lo   (head_s.addr_lo),
    .rt_old    (head_s.rt_old),
    .rdata     (head_s.rdata),
    .load_data (align_data_s)
  );

  // Queue state: push at wr, capture data at fill, release at rd; flush marks every slot cancelled
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_r   <= PTR_W'(0);
      fill_r <= PTR_W'(0);
      rd_r   <= PTR_W'(0);
      err_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i].done   <= 1'b0;
        ent_r[i].cancel <= 1'b0;
      end
    end else begin
      err_r <= data_data_ok & (fill_r == wr_r);
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent_r[i].cancel <= 1'b1;
        end
      end
      if (push_s) begin
        ent_r[wr_r[IDX_W-1:0]] <= '{is_load: req_is_load, load_op: req_load_op,
                                   addr_lo: req_addr_lo, rt_old: req_rt_old,
                                   rdata: 32'h0000_0000, done: 1'b0, cancel: flush};
        wr_r <= wr_r + PTR_W'(1);
      end
      if (fill_s) begin
        ent_r[fill_r[IDX_W-1:0]].rdata <= data_rdata;
        ent_r[fill_r[IDX_W-1:0]].done  <= 1'b1;
        fill_r <= fill_r + PTR_W'(1);
      end
      if (free_s) begin
        ent_r[rd_r[IDX_W-1:0]].done <= 1'b0;
        rd_r <= rd_r + PTR_W'(1);
      end
    end
  end

`ifdef MEM_RESP_OUT_REG_EN
  logic    out_valid_r, out_is_load_r, out_load_s;
  uint32_t out_data_r;

  assign out_load_s   = ~out_valid_r | resp_ready;
  assign pop_s        = head_valid_s & out_load_s;
  assign resp_valid   = out_valid_r & ~flush;
  assign resp_is_load = out_is_load_r;
  assign resp_data    = out_data_r;

  // Single output stage, refilled from the head whenever empty or being consumed
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_r   <= 1'b0;
      out_is_load_r <= 1'b0;
      out_data_r    <= 32'h0000_0000;
    end else if (out_load_s) begin
      out_valid_r   <= head_valid_s;
      out_is_load_r <= head_valid_s & head_s.is_load;
      out_data_r    <= head_valid_s ? head_data_s : 32'h0000_0000;
    end
  end
`else
  assign pop_s        = head_valid_s & resp_ready;
  assign resp_valid   = head_valid_s;
  assign resp_is_load = head_valid_s & head_s.is_load;
  assign resp_data    = head_valid_s ? head_data_s : 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: directed scenarios followed by randomized traffic against a queue model.
module tb_mem_resp;

`ifdef MEM_RESP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, req_fire, req_ready, req_is_load;
  logic [6:0]  req_load_op;
  logic [1:0]  req_addr_lo;
  logic [31:0] req_rt_old, data_rdata, resp_data;
  logic        data_data_ok, flush, resp_valid, resp_ready, resp_is_load, idle, err_unexp;

  always #5 clk = ~clk;

  mem_resp #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_load_op(req_load_op), .req_addr_lo(req_addr_lo),
    .req_rt_old(req_rt_old), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_is_load(resp_is_load), .resp_data(resp_data), .idle(idle), .err_unexp(err_unexp)
  );

  typedef struct { bit is_load; bit [6:0] op; bit [1:0] a; bit [31:0] rt; bit cancel; } pend_t;
  typedef struct { bit is_load; bit [31:0] data; } exp_t;

  pend_t pend_q[$];   // accepted requests still waiting for data_ok
  exp_t  exp_q[$];    // responses owed to WB, in order
  int    checks = 0;
  int    errors = 0;
  bit    err_req = 1'b0;
  bit    err_exp_r = 1'b0;
  exp_t  mon_e;

  // Reference load semantics written as shifts and masks
  function automatic bit [31:0] ref_load(pend_t e, bit [31:0] rd);
    bit [31:0] b, h;
    if (!e.is_load) return 32'h0;
    b = (rd >> (8 * e.a)) & 32'hFF;
    h = (rd >> (16 * e.a[1])) & 32'hFFFF;
    if (e.op[0]) return (b ^ 32'h80) - 32'h80;
    if (e.op[1]) return b;
    if (e.op[2]) return (h ^ 32'h8000) - 32'h8000;
    if (e.op[3]) return h;
    if (e.op[4]) return rd;
    if (e.op[5]) return (rd << (8 * (3 - e.a))) | (e.rt & 32'(64'hFFFF_FFFF >> (8 * (e.a + 1))));
    if (e.op[6]) return (rd >> (8 * e.a)) | (e.rt & ~(32'hFFFF_FFFF >> (8 * e.a)));
    return 32'h0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs (caller is just after a posedge) and advance the model
  task automatic apply(bit fire, bit ld, bit [6:0] op, bit [1:0] a, bit [31:0] rt,
                       bit dok, bit [31:0] rd, bit fl, bit rr);
    pend_t p;
    reset = 1'b0; req_fire = fire; req_is_load = ld; req_load_op = op; req_addr_lo = a;
    req_rt_old = rt; data_data_ok = dok; data_rdata = rd; flush = fl; resp_ready = rr;
    err_req = 1'b0;
    if (fl) begin
      foreach (pend_q[i]) pend_q[i].cancel = 1'b1;
      exp_q.delete();
    end
    if (dok) begin
      if (pend_q.size() == 0) err_req = 1'b1;
      else begin
        p = pend_q.pop_front();
        if (!p.cancel) exp_q.push_back(exp_t'{p.is_load, ref_load(p, rd)});
      end
    end
    if (fire) begin
      p = pend_t'{ld, op, a, rt, fl};
      pend_q.push_back(p);
    end
  endtask

  task automatic cyc(bit fire, bit ld, bit [6:0] op, bit [1:0] a, bit [31:0] rt,
                     bit dok, bit [31:0] rd, bit fl, bit rr);
    @(posedge clk); #1;
    apply(fire, ld, op, a, rt, dok, rd, fl, rr);
  endtask

  task automatic idle_cyc(bit rr);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, rr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_fire = 1'b0; req_is_load = 1'b0; req_load_op = 7'h00; req_addr_lo = 2'd0;
    req_rt_old = 32'h0; data_data_ok = 1'b0; data_rdata = 32'h0; flush = 1'b0; resp_ready = 1'b0;
    err_req = 1'b0;
    pend_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_resp(string nm, bit [31:0] exp);
    bit seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      idle_cyc(1'b1);
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        check(nm, resp_data, exp);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got no resp_valid, required resp_valid within 4 cycles", nm);
    end
  endtask

  always @(posedge clk) err_exp_r <= reset ? 1'b0 : err_req;

  // Monitor: pops the scoreboard whenever WB takes a response
  always @(negedge clk) begin
    if (!reset) begin
      check("err_unexp", err_unexp, err_exp_r);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid data %h, required no response", resp_data);
        end else if (resp_ready) begin
          mon_e = exp_q.pop_front();
          check("resp_is_load", resp_is_load, mon_e.is_load);
          check("resp_data", resp_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1);
  end

  initial begin
    bit fire, ld, dok, fl, rr;
    bit [6:0] op;
    bit [31:0] w1, w2;
    bit seen;
    reset = 1'b1; req_fire = 1'b0; req_is_load = 1'b0; req_load_op = 7'h00; req_addr_lo = 2'd0;
    req_rt_old = 32'h0; data_data_ok = 1'b0; data_rdata = 32'h0; flush = 1'b0; resp_ready = 1'b0;
    do_reset();
    do_reset();
    idle_cyc(1'b0);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_is_load", resp_is_load, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_idle", idle, 1'b1);

    // lb at byte 3, data_ok two cycles after issue
    cyc(1'b1, 1'b1, 7'h01, 2'd3, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle_cyc(1'b1);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk);
    check("lb_valid_early", resp_valid, 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      idle_cyc(1'b1);
      @(negedge clk);
      check("lb_latency", resp_valid, (k == LAT) ? 32'd1 : 32'd0);
      if (k == LAT) check("lb_data", resp_data, 32'hFFFF_FF80);
    end

    // lwl / lwr merges
    cyc(1'b1, 1'b1, 7'h20, 2'd1, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'hAABB_CCDD, 1'b0, 1'b1);
    expect_resp("lwl_data", 32'hCCDD_3344);
    cyc(1'b1, 1'b1, 7'h40, 2'd2, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'hAABB_CCDD, 1'b0, 1'b1);
    expect_resp("lwr_data", 32'h1122_AABB);

    // Two loads held while WB stalls, then delivered in order
    w1 = $urandom; w2 = $urandom;
    cyc(1'b1, 1'b1, 7'h10, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 7'h04, 2'd2, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, w1, 1'b0, 1'b0);
    @(negedge clk);
    check("full_req_ready", req_ready, 1'b0);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, w2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) idle_cyc(1'b0);
    @(negedge clk);
    check("held_valid", resp_valid, 1'b1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    @(negedge clk);
    check("ready_after_retire", req_ready, 1'b1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // Flush between the two data_oks: nothing delivered, queue drains to idle
    cyc(1'b1, 1'b1, 7'h10, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 7'h02, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("flush_valid", resp_valid, 1'b0);
    idle_cyc(1'b1);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'h9ABC_DEF0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      idle_cyc(1'b1);
      @(negedge clk);
      seen = idle;
    end
    check("flush_idle", idle, 1'b1);

    // Unexpected data_ok on an empty queue
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    @(negedge clk);
    check("err_idle", idle, 1'b1);
    check("err_req_ready", req_ready, 1'b1);

    // Reset with two outstanding, then a late data_ok
    cyc(1'b1, 1'b1, 7'h10, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 7'h00, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    do_reset();
    idle_cyc(1'b1);
    @(negedge clk);
    check("rst2_idle", idle, 1'b1);
    check("rst2_req_ready", req_ready, 1'b1);
    check("rst2_resp_valid", resp_valid, 1'b0);
    cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1);
    idle_cyc(1'b1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      ld   = ($urandom_range(0, 3) != 0);
      op   = ld ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
      fire = req_ready && ($urandom_range(0, 2) != 0);
      dok  = (pend_q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      fl   = ($urandom_range(0, 40) == 0);
      rr   = ($urandom_range(0, 9) < 7);
      apply(fire, ld, op, 2'($urandom_range(0, 3)), $urandom, dok, $urandom, fl, rr);
    end

    // Drain
    for (int k = 0; k < 30 && (pend_q.size() != 0 || exp_q.size() != 0); k++) begin
      cyc(1'b0, 1'b0, 7'h00, 2'd0, 32'h0, pend_q.size() != 0, $urandom, 1'b0, 1'b1);
    end
    for (int k = 0; k < 3; k++) idle_cyc(1'b1);
    @(negedge clk);
    check("drain_exp_q", exp_q.size(), 32'd0);
    check("drain_idle", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
